// File: rtl/polaris_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the Polaris I and D masters,
// with grant held until acknowledge and a watchdog that terminates stalled transfers.
module polaris_bus_arbiter #(
   parameter int TIMEOUT = 256,
   parameter int TW      = 9
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [1:0]  isiz_i,
   input  logic [63:0] iadr_i,
   output logic        iack_o,
   output logic [31:0] idat_o,
   input  logic        dcyc_i,
   input  logic        dstb_i,
   input  logic        dwe_i,
   input  logic [1:0]  dsiz_i,
   input  logic        dsigned_i,
   input  logic [63:0] dadr_i,
   input  logic [63:0] ddat_i,
   output logic        dack_o,
   output logic [63:0] ddat_o,
   output logic [63:0] madr_o,
   output logic [63:0] mdat_o,
   input  logic [63:0] mdat_i,
   output logic        mwe_o,
   output logic        mcyc_o,
   output logic        mstb_o,
   output logic [1:0]  msiz_o,
   output logic        msigned_o,
   input  logic        mack_i,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [TW-1:0] CNT_ONE  = TW'(1);

   state_t        state_reg;
   logic          last_d_reg;
   logic [TW-1:0] cnt_reg;
   logic          timeout_reg;

   logic i_req;
   logic d_req;
   logic gnt_i;
   logic gnt_d;
   logic granted;
   logic req_held;
   logic tmo_hit;

   assign i_req    = (isiz_i != 2'b00);
   assign d_req    = dcyc_i & dstb_i;
   assign gnt_i    = (state_reg == GNT_I);
   assign gnt_d    = (state_reg == GNT_D);
   assign granted  = gnt_i | gnt_d;
   assign req_held = gnt_i ? i_req : d_req;
   // A same-cycle acknowledge always beats the watchdog.
   assign tmo_hit  = (TIMEOUT != 0) && granted && (cnt_reg == CNT_LAST) && !mack_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg   <= IDLE;
         last_d_reg  <= 1'b0;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (d_req && (!i_req || !last_d_reg))
                  state_reg <= GNT_D;
               else if (i_req)
                  state_reg <= GNT_I;
            end
            GNT_I, GNT_D: begin
               if (mack_i || tmo_hit || !req_held) begin
                  state_reg  <= IDLE;
                  last_d_reg <= gnt_d;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
               if (tmo_hit)
                  timeout_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      madr_o    = '0;
      mdat_o    = '0;
      mwe_o     = 1'b0;
      msiz_o    = 2'b00;
      msigned_o = 1'b0;
      mcyc_o    = granted & ~tmo_hit;
      mstb_o    = granted & ~tmo_hit;
      iack_o    = 1'b0;
      idat_o    = '0;
      dack_o    = 1'b0;
      ddat_o    = '0;
      if (gnt_i) begin
         madr_o = iadr_i;
         msiz_o = isiz_i;
         iack_o = mack_i | tmo_hit;
         idat_o = tmo_hit ? 32'h0 : mdat_i[31:0];
      end else if (gnt_d) begin
         madr_o    = dadr_i;
         mdat_o    = ddat_i;
         mwe_o     = dwe_i;
         msiz_o    = dsiz_i;
         msigned_o = dsigned_i;
         dack_o    = mack_i | tmo_hit;
         ddat_o    = tmo_hit ? 64'h0 : mdat_i;
      end
   end

   assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Directed bench for polaris_bus_arbiter: acknowledged transfers are matched against a
// scoreboard of expected master/data pairs; other points use immediate checks.
module tb_polaris_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [1:0]  isiz_i;
   logic [63:0] iadr_i;
   logic        iack_o;
   logic [31:0] idat_o;
   logic        dcyc_i;
   logic        dstb_i;
   logic        dwe_i;
   logic [1:0]  dsiz_i;
   logic        dsigned_i;
   logic [63:0] dadr_i;
   logic [63:0] ddat_i;
   logic        dack_o;
   logic [63:0] ddat_o;
   logic [63:0] madr_o;
   logic [63:0] mdat_o;
   logic [63:0] mdat_i;
   logic        mwe_o;
   logic        mcyc_o;
   logic        mstb_o;
   logic [1:0]  msiz_o;
   logic        msigned_o;
   logic        mack_i;
   logic        timeout_o;

   always #5 clk_i = ~clk_i;

   polaris_bus_arbiter #(.TIMEOUT(8), .TW(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .isiz_i(isiz_i), .iadr_i(iadr_i), .iack_o(iack_o), .idat_o(idat_o),
      .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dsiz_i(dsiz_i),
      .dsigned_i(dsigned_i), .dadr_i(dadr_i), .ddat_i(ddat_i),
      .dack_o(dack_o), .ddat_o(ddat_o),
      .madr_o(madr_o), .mdat_o(mdat_o), .mdat_i(mdat_i), .mwe_o(mwe_o),
      .mcyc_o(mcyc_o), .mstb_o(mstb_o), .msiz_o(msiz_o), .msigned_o(msigned_o),
      .mack_i(mack_i), .timeout_o(timeout_o)
   );

   typedef struct {
      logic        is_d;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Settle inputs, then retire any acknowledge against the scoreboard.
   task automatic look();
      exp_t e;
      logic [63:0] got;
      #3;
      if (iack_o || dack_o) begin
         check("sb_pending", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = dack_o ? ddat_o : {32'h0, idat_o};
            check("sb_master", 64'(dack_o), 64'(e.is_d));
            check("sb_data", got, e.data);
            $display("ack %s data=%h", dack_o ? "D" : "I", got);
         end
      end
   endtask

   initial begin
      int   k;
      int   rises;
      int   lows;
      logic last_mcyc;
      logic last_ack;

      // T1: reset with both masters requesting
      reset_i = 1'b1; isiz_i = 2'b10; iadr_i = 64'h0; dcyc_i = 1'b1; dstb_i = 1'b1;
      dwe_i = 1'b0; dsiz_i = 2'b11; dsigned_i = 1'b0; dadr_i = 64'h1000; ddat_i = 64'h0;
      mdat_i = 64'h0; mack_i = 1'b0;
      tick(); tick();
      look();
      check("rst_mcyc", {63'h0, mcyc_o}, 64'd0);
      check("rst_mstb", {63'h0, mstb_o}, 64'd0);
      check("rst_madr", madr_o, 64'h0);
      check("rst_acks", {62'h0, iack_o, dack_o}, 64'd0);
      check("rst_tmo", {63'h0, timeout_o}, 64'd0);
      reset_i = 1'b0;
      tick(); look();
      check("t1_mcyc", {63'h0, mcyc_o}, 64'd1);
      check("t1_madr_d", madr_o, 64'h1000);
      check("t1_msiz", {62'h0, msiz_o}, 64'd3);
      // Withdrawal: granted D drops its request, no ack
      dcyc_i = 1'b0; dstb_i = 1'b0; isiz_i = 2'b00;
      look();
      check("wd_noack", {63'h0, dack_o}, 64'd0);
      tick(); look();
      check("wd_idle", {63'h0, mcyc_o}, 64'd0);

      // Reset pulse to restore last_d=0 before contention
      reset_i = 1'b1; tick(); reset_i = 1'b0;

      // T4: continuous contention, slave acks the cycle after it sees the strobe
      isiz_i = 2'b10; iadr_i = 64'hA0; dcyc_i = 1'b1; dstb_i = 1'b1; dadr_i = 64'hD0;
      for (int t = 0; t < 4; t++) begin
         if (t % 2 == 0) sb.push_back('{1'b1, {32'hCAFE_0000 | 32'(t), 32'h0000_1000 | 32'(t)}});
         else            sb.push_back('{1'b0, {32'h0, 32'h0000_1000 | 32'(t)}});
      end
      k = 0; rises = 0; lows = 0; last_mcyc = 1'b0;
      mack_i = 1'b0;
      for (int c = 0; c < 12; c++) begin
         mdat_i = {32'hCAFE_0000 | 32'(k), 32'h0000_1000 | 32'(k)};
         look();
         if (mcyc_o && !last_mcyc) rises++;
         if (!mcyc_o) lows++;
         last_ack = iack_o | dack_o;
         if (last_ack) k++;
         last_mcyc = mcyc_o;
         tick();
         mack_i = last_mcyc & ~last_ack;
      end
      check("t4_starts", 64'(rises), 64'd4);
      check("t4_idle_cycles", 64'(lows), 64'd4);
      check("t4_sb_drained", 64'(sb.size()), 64'd0);
      isiz_i = 2'b00; dcyc_i = 1'b0; dstb_i = 1'b0; mack_i = 1'b0;
      tick();

      // T2: I fetch with two wait states
      isiz_i = 2'b10; iadr_i = 64'hFFFF_FFFF_FFFF_FF00; mdat_i = 64'hDEAD_BEEF_0000_0000;
      look();
      check("t2_idle", {63'h0, mcyc_o}, 64'd0);
      tick(); look();
      check("t2_mcyc", {63'h0, mcyc_o}, 64'd1);
      check("t2_madr", madr_o, 64'hFFFF_FFFF_FFFF_FF00);
      check("t2_msiz", {62'h0, msiz_o}, 64'd2);
      check("t2_wait1_iack", {63'h0, iack_o}, 64'd0);
      tick(); look();
      check("t2_wait2_iack", {63'h0, iack_o}, 64'd0);
      tick();
      mack_i = 1'b1; mdat_i = 64'h0000_0000_0000_0013;
      sb.push_back('{1'b0, 64'h13});
      look();
      check("t2_iack", {63'h0, iack_o}, 64'd1);
      check("t2_idat", {32'h0, idat_o}, 64'h13);
      check("t2_dack", {63'h0, dack_o}, 64'd0);
      tick();
      mack_i = 1'b0; isiz_i = 2'b00;
      look();
      check("t2_iack_once", {63'h0, iack_o}, 64'd0);
      check("t2_back_idle", {63'h0, mcyc_o}, 64'd0);

      // T3: D half-word load, zero wait
      dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b0; dsiz_i = 2'b01; dsigned_i = 1'b0;
      dadr_i = 64'hFFFF_FFFF_DEAD_B123;
      look(); tick();
      mack_i = 1'b1; mdat_i = 64'h0000_0000_0000_FFFC;
      sb.push_back('{1'b1, 64'hFFFC});
      look();
      check("t3_madr", madr_o, 64'hFFFF_FFFF_DEAD_B123);
      check("t3_msiz", {62'h0, msiz_o}, 64'd1);
      check("t3_mwe", {63'h0, mwe_o}, 64'd0);
      check("t3_dack", {63'h0, dack_o}, 64'd1);
      check("t3_ddat", ddat_o, 64'h0000_0000_0000_FFFC);
      check("t3_iack", {63'h0, iack_o}, 64'd0);
      tick();
      mack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
      look();
      check("t3_dack_once", {63'h0, dack_o}, 64'd0);

      // T5: watchdog terminates a dead I fetch on its 8th grant cycle
      isiz_i = 2'b10; iadr_i = 64'h200; mdat_i = 64'hFFFF_FFFF_FFFF_FFFF;
      sb.push_back('{1'b0, 64'h0});
      look();
      for (int g = 1; g <= 8; g++) begin
         tick(); look();
         if (g < 8) begin
            check($sformatf("t5_wait%0d_iack", g), {63'h0, iack_o}, 64'd0);
            check($sformatf("t5_wait%0d_mcyc", g), {63'h0, mcyc_o}, 64'd1);
         end
      end
      check("t5_iack", {63'h0, iack_o}, 64'd1);
      check("t5_idat", {32'h0, idat_o}, 64'h0);
      check("t5_mcyc_drop", {63'h0, mcyc_o}, 64'd0);
      check("t5_tmo_not_yet", {63'h0, timeout_o}, 64'd0);
      tick();
      isiz_i = 2'b00;
      look();
      check("t5_tmo_set", {63'h0, timeout_o}, 64'd1);
      check("t5_idle", {63'h0, mcyc_o}, 64'd0);
      // Next D write served normally
      dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b1; dsiz_i = 2'b11; dadr_i = 64'h300;
      ddat_i = 64'h55;
      tick();
      mack_i = 1'b1; mdat_i = 64'h1234;
      sb.push_back('{1'b1, 64'h1234});
      look();
      check("t5d_mwe", {63'h0, mwe_o}, 64'd1);
      check("t5d_mdat", mdat_o, 64'h55);
      check("t5d_dack", {63'h0, dack_o}, 64'd1);
      check("t5d_tmo_held", {63'h0, timeout_o}, 64'd1);
      tick();
      mack_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0;
      look();

      // T6: reset lands in the second wait cycle of a D write
      dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b1; dadr_i = 64'h400; ddat_i = 64'hAA;
      tick(); look();
      tick();
      reset_i = 1'b1;
      look();
      check("t6_pre_mcyc", {63'h0, mcyc_o}, 64'd1);
      check("t6_pre_mwe", {63'h0, mwe_o}, 64'd1);
      tick(); look();
      check("t6_mcyc", {63'h0, mcyc_o}, 64'd0);
      check("t6_mwe", {63'h0, mwe_o}, 64'd0);
      check("t6_dack", {63'h0, dack_o}, 64'd0);
      check("t6_tmo_clr", {63'h0, timeout_o}, 64'd0);
      reset_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0; mack_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(); look();
         check($sformatf("t6_stray_ack%0d", c), {62'h0, iack_o, dack_o}, 64'd0);
      end
      mack_i = 1'b0;
      check("sb_final_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
